// File: rtl/mem_port_req.sv
// MEM-stage load/store requester driving the memory controller's MEM-side port.
// Optional MEMPORT_POSTED_STORE_EN: stores respond right after acceptance and complete in ST_PEND.
module mem_port_req #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              req_valid_i,
   input  logic              req_load_i,
   input  logic [1:0]        req_size_i,
   input  logic              req_sign_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_wdata_i,
   output logic              stall_o,
   output logic              resp_valid_o,
   output logic [DATA_W-1:0] resp_data_o,
   output logic [1:0]        mem_re_o,
   output logic              mem_rsign_o,
   output logic [1:0]        mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_busy_i,
   input  logic              mem_done_i,
   input  logic [DATA_W-1:0] mem_data_i
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_ACC,
      WAIT_DONE,
      RESP
`ifdef MEMPORT_POSTED_STORE_EN
      , ST_PEND
`endif
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_load;
   logic              r_sign;
   logic [1:0]        r_size;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_resp_data;
   logic              w_latch;
   logic              w_noop;
   logic              w_capture;
   logic              w_drive;
`ifdef MEMPORT_POSTED_STORE_EN
   logic              r_pend;
   logic              w_accept;
`endif

   always_comb begin
      w_next    = r_state;
      w_latch   = 1'b0;
      w_noop    = 1'b0;
      w_capture = 1'b0;
`ifdef MEMPORT_POSTED_STORE_EN
      w_accept  = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            if (req_valid_i) begin
               if (req_size_i != 2'b00) begin
                  w_latch = 1'b1;
                  w_next  = WAIT_ACC;
               end else begin
                  w_noop = 1'b1;
                  w_next = RESP;
               end
            end
         end
         // a done seen before acceptance is an IF completion and is ignored
         WAIT_ACC: begin
            if (!mem_busy_i && !mem_done_i) begin
`ifdef MEMPORT_POSTED_STORE_EN
               w_accept = 1'b1;
               w_next   = r_load ? WAIT_DONE : RESP;
`else
               w_next   = WAIT_DONE;
`endif
            end
         end
         WAIT_DONE: begin
            if (mem_done_i) begin
               w_capture = 1'b1;
               w_next    = RESP;
            end
         end
         RESP: begin
`ifdef MEMPORT_POSTED_STORE_EN
            // a hit store may already finish during its response cycle
            w_next = (r_pend && !mem_done_i) ? ST_PEND : IDLE;
`else
            w_next = IDLE;
`endif
         end
`ifdef MEMPORT_POSTED_STORE_EN
         ST_PEND: begin
            if (mem_done_i) w_next = IDLE;
         end
`endif
         default: w_next = IDLE;
      endcase
   end

`ifdef MEMPORT_POSTED_STORE_EN
   assign w_drive = (r_state == WAIT_ACC) || (r_state == WAIT_DONE) ||
                    (r_state == ST_PEND) || ((r_state == RESP) && r_pend);
`else
   assign w_drive = (r_state == WAIT_ACC) || (r_state == WAIT_DONE);
`endif

   // request fields drop in any done cycle so a finished access is never re-sampled
   assign mem_re_o     = (w_drive && r_load && !mem_done_i)  ? r_size : 2'b00;
   assign mem_we_o     = (w_drive && !r_load && !mem_done_i) ? r_size : 2'b00;
   assign mem_addr_o   = r_addr;
   assign mem_wdata_o  = r_wdata;
   assign mem_rsign_o  = r_sign;
   assign resp_valid_o = (r_state == RESP);
   assign resp_data_o  = r_resp_data;
   assign stall_o      = req_valid_i && (r_state != RESP);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_load      <= 1'b0;
         r_sign      <= 1'b0;
         r_size      <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_resp_data <= '0;
`ifdef MEMPORT_POSTED_STORE_EN
         r_pend      <= 1'b0;
`endif
      end else if (rdy) begin
         r_state <= w_next;
         if (w_latch) begin
            r_load  <= req_load_i;
            r_sign  <= req_sign_i;
            r_size  <= req_size_i;
            r_addr  <= req_addr_i;
            r_wdata <= req_wdata_i;
         end
         if (w_noop) r_resp_data <= '0;
         if (w_capture) r_resp_data <= r_load ? mem_data_i : '0;
`ifdef MEMPORT_POSTED_STORE_EN
         if (w_accept && !r_load) begin
            r_resp_data <= '0;
            r_pend      <= 1'b1;
         end else if (((r_state == RESP) || (r_state == ST_PEND)) && mem_done_i) begin
            r_pend <= 1'b0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_mem_port_req.sv
// Directed bench for mem_port_req: transaction-level model checked every cycle plus literal pins.
// Honours MEMPORT_POSTED_STORE_EN for the posted-store scenario.
module tb_mem_port_req;

   logic        clk;
   logic        rst, rdy, v, ld, sg, busy, done;
   logic [1:0]  sz;
   logic [31:0] ad, wd, rdata;
   logic        stall_o, resp_valid_o, mem_rsign_o;
   logic [31:0] resp_data_o, mem_addr_o, mem_wdata_o;
   logic [1:0]  mem_re_o, mem_we_o;

   int n_checks = 0;
   int n_fail   = 0;
   int n_acc    = 0;
   int snap;

   mem_port_req #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .req_valid_i(v), .req_load_i(ld), .req_size_i(sz), .req_sign_i(sg),
      .req_addr_i(ad), .req_wdata_i(wd),
      .stall_o(stall_o), .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o),
      .mem_re_o(mem_re_o), .mem_rsign_o(mem_rsign_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_busy_i(busy), .mem_done_i(done), .mem_data_i(rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: one outstanding operation described by what it is waiting for.
   logic        m_live = 0;
   logic        m_issued = 0, m_inflight = 0, m_resp = 0, m_posted = 0;
   logic        m_ld = 0, m_sg = 0;
   logic [1:0]  m_sz = 0;
   logic [31:0] m_ad = 0, m_wd = 0, m_rdata = 0;
   logic        e_drv;
   logic [1:0]  e_re, e_we;

   always @(negedge clk) begin
      if (m_live) begin
         e_drv = m_issued || m_inflight || m_posted;
         e_re  = (e_drv && m_ld && !done)  ? m_sz : 2'b00;
         e_we  = (e_drv && !m_ld && !done) ? m_sz : 2'b00;
         cmp("m_stall", {31'b0, stall_o}, {31'b0, v && !m_resp});
         cmp("m_resp_valid", {31'b0, resp_valid_o}, {31'b0, m_resp});
         cmp("m_resp_data", resp_data_o, m_rdata);
         cmp("m_re", {30'b0, mem_re_o}, {30'b0, e_re});
         cmp("m_we", {30'b0, mem_we_o}, {30'b0, e_we});
         cmp("m_addr", mem_addr_o, m_ad);
         cmp("m_wdata", mem_wdata_o, m_wd);
         cmp("m_rsign", {31'b0, mem_rsign_o}, {31'b0, m_sg});
      end
      if (rdy && !rst && (mem_re_o != 2'b00 || mem_we_o != 2'b00) && !busy && !done) n_acc++;
      if (rst) begin
         m_issued = 0; m_inflight = 0; m_resp = 0; m_posted = 0;
         m_ld = 0; m_sg = 0; m_sz = 0; m_ad = 0; m_wd = 0; m_rdata = 0;
         m_live = 1;
      end else if (rdy && m_live) begin
         if (m_resp) begin
            m_resp = 0;
            if (m_posted && done) m_posted = 0;
         end else if (m_posted) begin
            if (done) m_posted = 0;
         end else if (m_issued) begin
            if (!busy && !done) begin
               m_issued = 0;
`ifdef MEMPORT_POSTED_STORE_EN
               if (!m_ld) begin
                  m_resp = 1; m_rdata = 0; m_posted = 1;
               end else m_inflight = 1;
`else
               m_inflight = 1;
`endif
            end
         end else if (m_inflight) begin
            if (done) begin
               m_inflight = 0; m_resp = 1;
               m_rdata = m_ld ? rdata : 32'h0;
            end
         end else if (v) begin
            if (sz != 2'b00) begin
               m_issued = 1; m_ld = ld; m_sz = sz; m_sg = sg; m_ad = ad; m_wd = wd;
            end else begin
               m_resp = 1; m_rdata = 0;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic op(input logic l, input logic [1:0] s, input logic sgn,
                     input logic [31:0] a, input logic [31:0] w);
      v = 1; ld = l; sz = s; sg = sgn; ad = a; wd = w;
   endtask

   task automatic quiet();
      v = 0; ld = 0; sz = 0; sg = 0; ad = 0; wd = 0; busy = 0; done = 0; rdata = 0;
   endtask

   initial begin
      rst = 1; rdy = 1;
      quiet();
      step(); step();
      #1;
      cmp("rst_resp_valid", {31'b0, resp_valid_o}, 32'h0);
      cmp("rst_resp_data", resp_data_o, 32'h0);
      cmp("rst_re", {30'b0, mem_re_o}, 32'h0);
      cmp("rst_we", {30'b0, mem_we_o}, 32'h0);
      cmp("rst_addr", mem_addr_o, 32'h0);
      rst = 0;
      step();

      // word load, cache hit
      step(); op(1, 2'b11, 0, 32'h100, 0); #1 cmp("t1_stall_c0", {31'b0, stall_o}, 32'h1);
      step(); #1 cmp("t1_re_c1", {30'b0, mem_re_o}, 32'h3);
      step(); done = 1; rdata = 32'hDEADBEEF;
      #1 cmp("t1_re_done", {30'b0, mem_re_o}, 32'h0);
      cmp("t1_stall_c2", {31'b0, stall_o}, 32'h1);
      step(); done = 0; rdata = 0;
      #1 cmp("t1_resp_valid", {31'b0, resp_valid_o}, 32'h1);
      cmp("t1_resp_data", resp_data_o, 32'hDEADBEEF);
      cmp("t1_stall_c3", {31'b0, stall_o}, 32'h0);
      step(); quiet(); #1 cmp("t1_resp_once", {31'b0, resp_valid_o}, 32'h0);

      // size 00: immediate response, no access
      step(); op(1, 2'b00, 0, 32'h999, 0);
      step(); #1 cmp("noop_resp_valid", {31'b0, resp_valid_o}, 32'h1);
      cmp("noop_resp_data", resp_data_o, 32'h0);
      cmp("noop_addr_kept", mem_addr_o, 32'h100);
      step(); quiet();

`ifndef MEMPORT_POSTED_STORE_EN
      // byte store, miss
      step(); op(0, 2'b01, 0, 32'h20004, 32'hA5);
      step(); #1 cmp("t2_we_c1", {30'b0, mem_we_o}, 32'h1);
      step(); busy = 1;
      step(); busy = 1; #1 cmp("t2_we_busy", {30'b0, mem_we_o}, 32'h1);
      cmp("t2_wdata", mem_wdata_o, 32'hA5);
      cmp("t2_addr", mem_addr_o, 32'h20004);
      step(); busy = 0; done = 1; #1 cmp("t2_we_done", {30'b0, mem_we_o}, 32'h0);
      step(); done = 0; #1 cmp("t2_resp_valid", {31'b0, resp_valid_o}, 32'h1);
      cmp("t2_resp_data", resp_data_o, 32'h0);
      step(); quiet();
`endif

      // IF done while waiting for acceptance
      step(); op(1, 2'b01, 1, 32'h41, 0);
      step(); busy = 1; #1 cmp("t3_re_c1", {30'b0, mem_re_o}, 32'h1);
      cmp("t3_rsign", {31'b0, mem_rsign_o}, 32'h1);
      step(); busy = 0; done = 1; #1 cmp("t3_re_ifdone", {30'b0, mem_re_o}, 32'h0);
      step(); done = 0; #1 cmp("t3_re_still", {30'b0, mem_re_o}, 32'h1);
      step(); done = 1; rdata = 32'hFFFFFF80; #1 cmp("t3_no_early_resp", {31'b0, resp_valid_o}, 32'h0);
      step(); done = 0; rdata = 0; #1 cmp("t3_resp_valid", {31'b0, resp_valid_o}, 32'h1);
      cmp("t3_resp_data", resp_data_o, 32'hFFFFFF80);
      step(); quiet();

`ifndef MEMPORT_POSTED_STORE_EN
      // back-to-back load then store, req_valid held
      step(); snap = n_acc; op(1, 2'b11, 0, 32'h600, 0);
      step();
      step(); done = 1; rdata = 32'hA1B2C3D4;
      step(); done = 0; rdata = 0; #1 cmp("t4_load_data", resp_data_o, 32'hA1B2C3D4);
      step(); op(0, 2'b11, 0, 32'h604, 32'h0BADCAFE);
      #1 cmp("t4_stall_c4", {31'b0, stall_o}, 32'h1);
      cmp("t4_we_c4", {30'b0, mem_we_o}, 32'h0);
      step(); #1 cmp("t4_we_c5", {30'b0, mem_we_o}, 32'h3);
      step(); done = 1; #1 cmp("t4_we_done", {30'b0, mem_we_o}, 32'h0);
      cmp("t4_re_done", {30'b0, mem_re_o}, 32'h0);
      step(); done = 0; #1 cmp("t4_resp_valid", {31'b0, resp_valid_o}, 32'h1);
      cmp("t4_resp_data", resp_data_o, 32'h0);
      step(); quiet(); #1 cmp("t4_accesses", n_acc - snap, 32'd2);
`endif

      // rdy low for 3 cycles in WAIT_DONE with done held
      step(); op(1, 2'b11, 0, 32'h80, 0);
      step();
      step(); rdy = 0; done = 1; rdata = 32'hCAFEF00D;
      step();
      step(); #1 cmp("t5_frozen_resp", {31'b0, resp_valid_o}, 32'h0);
      cmp("t5_frozen_re", {30'b0, mem_re_o}, 32'h0);
      cmp("t5_frozen_stall", {31'b0, stall_o}, 32'h1);
      step(); rdy = 1;
      step(); done = 0; rdata = 0; #1 cmp("t5_resp_valid", {31'b0, resp_valid_o}, 32'h1);
      cmp("t5_resp_data", resp_data_o, 32'hCAFEF00D);
      step(); quiet(); #1 cmp("t5_resp_once", {31'b0, resp_valid_o}, 32'h0);

      // reset mid-operation
      step(); op(1, 2'b10, 0, 32'h500, 0);
      step(); busy = 1; #1 cmp("t6_re_c1", {30'b0, mem_re_o}, 32'h2);
      step(); rst = 1; #1 cmp("t6_re_c2", {30'b0, mem_re_o}, 32'h2);
      step(); rst = 0; quiet(); #1 cmp("t6_re_after", {30'b0, mem_re_o}, 32'h0);
      cmp("t6_addr_after", mem_addr_o, 32'h0);
      step();

`ifdef MEMPORT_POSTED_STORE_EN
      // posted word store followed by a load
      step(); op(0, 2'b11, 0, 32'h300, 32'h11223344);
      step(); #1 cmp("p_we_c1", {30'b0, mem_we_o}, 32'h3);
      step(); busy = 1; #1 cmp("p_resp_valid", {31'b0, resp_valid_o}, 32'h1);
      cmp("p_resp_data", resp_data_o, 32'h0);
      cmp("p_we_c2", {30'b0, mem_we_o}, 32'h3);
      cmp("p_stall_c2", {31'b0, stall_o}, 32'h0);
      step(); op(1, 2'b11, 0, 32'h304, 0); busy = 1;
      #1 cmp("p_stall_pend", {31'b0, stall_o}, 32'h1);
      cmp("p_we_pend", {30'b0, mem_we_o}, 32'h3);
      step(); busy = 0; done = 1; #1 cmp("p_we_done", {30'b0, mem_we_o}, 32'h0);
      cmp("p_stall_done", {31'b0, stall_o}, 32'h1);
      step(); done = 0; #1 cmp("p_re_c5", {30'b0, mem_re_o}, 32'h0);
      cmp("p_addr_c5", mem_addr_o, 32'h300);
      step(); #1 cmp("p_re_c6", {30'b0, mem_re_o}, 32'h3);
      cmp("p_addr_c6", mem_addr_o, 32'h304);
      step(); done = 1; rdata = 32'h55;
      step(); done = 0; rdata = 0; #1 cmp("p_load_resp", {31'b0, resp_valid_o}, 32'h1);
      cmp("p_load_data", resp_data_o, 32'h55);
      step(); quiet();
`endif

      repeat (3) step();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_req.md
Name: mem_port_req

Overview:
- Load/store requester for the MEM pipeline stage. It is the initiator that drives the memory controller's MEM-side request port.
- Upstream, it takes one load/store from the EX/MEM stage and stalls the pipeline until the access completes.
- Downstream, it holds the request stable and tells its own completion apart from IF completions on the shared busy/done lines.
- It returns load data to the pipeline with a one-cycle response pulse.

Parameters:
ADDR_W, 32, width of the address bus.
DATA_W, 32, width of the data bus (must be 32).

Ports:
clk  input  1  clock
rst  input  1  reset
rdy  input  1  global enable; low freezes all registers
req_valid_i  input  1  pipeline presents a memory op
req_load_i  input  1  1=load, 0=store
req_size_i  input  2  01 byte, 10 half, 11 word (00 treated as no op)
req_sign_i  input  1  sign-extend load
req_addr_i  input  ADDR_W  byte address
req_wdata_i  input  DATA_W  store data, LSB-aligned
stall_o  output  1  hold pipeline
resp_valid_o  output  1  one-cycle completion pulse
resp_data_o  output  DATA_W  load result (0 for stores)
mem_re_o  output  2  read size to controller
mem_rsign_o  output  1  load sign
mem_we_o  output  2  write size to controller
mem_addr_o  output  ADDR_W  address to controller
mem_wdata_o  output  DATA_W  write data to controller
mem_busy_i  input  1  controller busy
mem_done_i  input  1  controller done (shared with IF)
mem_data_i  input  DATA_W  controller read data

Interface: one clock, clk; reset rst is synchronous and active-high. rdy=0 holds state and all registered outputs.

Behaviour:
- States: IDLE, WAIT_ACC, WAIT_DONE, RESP.
- Reset values: state=IDLE, resp_valid_o=0, resp_data_o=0. All request registers are 0, so mem_re_o=mem_we_o=00 and mem_addr_o/mem_wdata_o/mem_rsign_o=0.
- IDLE:
  - If req_valid_i=1 and req_size_i!=00: latch load, size, sign, addr and wdata; go to WAIT_ACC.
  - req_size_i=00 with req_valid_i=1: go directly to RESP with resp_data_o=0 (no memory access).
- Request drive:
  - In WAIT_ACC and WAIT_DONE, mem_re_o = size if load, and mem_we_o = size if store; the other field is 00.
  - Both fields are forced to 00 combinationally in any cycle with mem_done_i=1, so the controller never re-samples a finished request.
  - Address, wdata and sign are held stable from WAIT_ACC through RESP. The controller reads them live during multi-cycle transfers.
- WAIT_ACC:
  - The request is accepted on a clock edge where mem_busy_i=0 and mem_done_i=0; go to WAIT_DONE.
  - A mem_done_i seen in WAIT_ACC belongs to IF and is ignored.
- WAIT_DONE:
  - On mem_done_i=1, capture resp_data_o = load ? mem_data_i : 0 and go to RESP.
  - mem_busy_i may stay 0 throughout (cache hit); done then arrives one cycle after acceptance.
- RESP: resp_valid_o=1 for exactly one cycle, then unconditionally return to IDLE. A new request is never latched in RESP.
- stall_o = req_valid_i && (state != RESP) (combinational).
  - Minimum latency (cache hit): request in cycle 0, accept edge end of cycle 1, done in cycle 2, RESP in cycle 3.
  - Pipeline advances at the end of cycle 3.
- Reset mid-operation returns to IDLE and drops requests next cycle. Controller recovery is the controller's own reset.

Optional Feature:
- Macro: MEMPORT_POSTED_STORE_EN.
- With the macro: a store enters RESP right after acceptance (WAIT_ACC to RESP, resp_data_o=0), then goes to the ST_PEND state.
  - ST_PEND keeps driving the store and waits for its done.
  - A new request arriving in ST_PEND is stalled (stall_o=1) until that done, then latched in the following cycle.
  - Loads behave as without the macro.
- Without the macro: stores wait for done like loads, and ST_PEND does not exist.

Test Plan:
- Word load, hit: addr 0x100, size 11, controller done in cycle 2 with data 0xDEADBEEF -> resp_valid_o=1 in cycle 3, resp_data_o=0xDEADBEEF, stall_o=1 in cycles 0-2 and 0 in cycle 3.
- Byte store, miss: addr 0x20004, wdata 0x000000A5, busy high 2 cycles -> mem_we_o=01 and mem_wdata_o held until done; mem_we_o=00 in the done cycle; resp_data_o=0.
- IF fetch in flight: busy=1, then IF done pulse while in WAIT_ACC -> pulse ignored, accept on the next idle edge; the single later done completes the load.
- Back-to-back load then store with req_valid_i held -> exactly two controller accesses, and no duplicate request in any done cycle.
- rdy=0 for 3 cycles during WAIT_DONE with done held high -> state frozen; completes normally after rdy returns.
- With MEMPORT_POSTED_STORE_EN: word store followed by a load -> resp for the store one cycle after accept; the load stalls until the store's done, then issues.
